dmem_dump_reader: RTL and testbench

//   Post-run data-memory dump engine. On a start pulse, reads NUM_WORDS consecutive words from a

---
 rtl/dmem_dump_reader.sv | 138 +++++++++++++
 tb/tb_dmem_dump_reader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_reader.sv
// Post-run data-memory dump engine: reads NUM_WORDS words from BASE_ADDR and streams (addr, data).
// Latency: start edge -> first out_valid after 3 rising edges; at most one word per 3 cycles.
// Backpressure: a word is held stable in HOLD until out_ready; no new read is issued meanwhile.
module dmem_dump_reader #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    NUM_WORDS  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic                  o_mem_re,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic [ADDR_WIDTH-1:0] o_out_addr,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_HOLD,
      S_DONE
   } state_t;

   // Index of the final word; only meaningful when the dump is non-empty.
   localparam logic [15:0]           C_LAST  = 16'((NUM_WORDS == 0) ? 0 : NUM_WORDS - 1);
   localparam bit                    C_EMPTY = (NUM_WORDS == 0);
   localparam logic [ADDR_WIDTH-1:0] C_STEP  = ADDR_WIDTH'(4);

   state_t                r_state;
   logic [15:0]           r_cnt;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic                  r_mem_re;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [ADDR_WIDTH-1:0] r_out_addr;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_last;

   assign w_last = (r_cnt == C_LAST);

   // Dump sequencer; every output is a register so consumers see glitch-free levels.
   // The current word address doubles as the memory address, which is only qualified by mem_re.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_cur_addr  <= '0;
         r_mem_re    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_addr  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (i_abort && (r_state != S_IDLE)) begin
         // Cancel wins over a same-cycle handshake: the offered word is dropped.
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mem_re    <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_cur_addr <= BASE_ADDR;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  if (C_EMPTY) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= S_READ;
                     r_mem_re <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_mem_re <= 1'b0;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               r_out_data  <= i_mem_rdata;
               r_out_addr  <= r_cur_addr;
               r_out_valid <= 1'b1;
               r_state     <= S_HOLD;
            end
            S_HOLD: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     // Address wraps naturally at the register width.
                     r_cnt      <= r_cnt + 16'd1;
                     r_cur_addr <= r_cur_addr + C_STEP;
                     r_mem_re   <= 1'b1;
                     r_state    <= S_READ;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_mem_re    <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign o_mem_re    = r_mem_re;
   assign o_mem_addr  = r_cur_addr;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_addr  = r_out_addr;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Bench for dmem_dump_reader: scoreboard of expected (addr, data) words checked by a monitor.
// Three instances: a 4-word dump from 0, an empty dump, and a dump that wraps the address space.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_dump_reader;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NW = 4;
   localparam logic [AW-1:0] W_BASE = 32'hFFFF_FFF8;
   localparam int W_NW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- main instance ----------------
   logic          m_start = 1'b0, m_abort = 1'b0, m_ready = 1'b1;
   logic          m_re, m_valid, m_busy, m_done;
   logic [AW-1:0] m_maddr, m_oaddr;
   logic [DW-1:0] m_rdata = '0, m_odata;
   logic [DW-1:0] mem [0:15];

   dmem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR('0), .NUM_WORDS(NW)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(m_start), .i_abort(m_abort),
      .o_mem_re(m_re), .o_mem_addr(m_maddr), .i_mem_rdata(m_rdata),
      .o_out_valid(m_valid), .i_out_ready(m_ready), .o_out_data(m_odata),
      .o_out_addr(m_oaddr), .o_busy(m_busy), .o_done(m_done));

   // Synchronous-read memory: data appears the cycle after the read enable.
   always @(posedge clk) if (m_re) m_rdata <= mem[m_maddr[5:2]];

   // ---------------- empty-dump instance ----------------
   logic          z_start = 1'b0, z_abort = 1'b0, z_ready = 1'b1;
   logic          z_re, z_valid, z_busy, z_done;
   logic [AW-1:0] z_maddr, z_oaddr;
   logic [DW-1:0] z_rdata = '0, z_odata;

   dmem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR('0), .NUM_WORDS(0)) u_zero (
      .clk(clk), .rst_n(rst_n), .i_start(z_start), .i_abort(z_abort),
      .o_mem_re(z_re), .o_mem_addr(z_maddr), .i_mem_rdata(z_rdata),
      .o_out_valid(z_valid), .i_out_ready(z_ready), .o_out_data(z_odata),
      .o_out_addr(z_oaddr), .o_busy(z_busy), .o_done(z_done));

   // ---------------- wrapping instance ----------------
   logic          w_start = 1'b0, w_abort = 1'b0, w_ready = 1'b1;
   logic          w_re, w_valid, w_busy, w_done;
   logic [AW-1:0] w_maddr, w_oaddr;
   logic [DW-1:0] w_rdata = '0, w_odata;

   dmem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(W_BASE), .NUM_WORDS(W_NW)) u_wrap (
      .clk(clk), .rst_n(rst_n), .i_start(w_start), .i_abort(w_abort),
      .o_mem_re(w_re), .o_mem_addr(w_maddr), .i_mem_rdata(w_rdata),
      .o_out_valid(w_valid), .i_out_ready(w_ready), .o_out_data(w_odata),
      .o_out_addr(w_oaddr), .o_busy(w_busy), .o_done(w_done));

   // Memory content for the wrapping instance is a function of the address.
   always @(posedge clk) if (w_re) w_rdata <= ~w_maddr;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            last;
   } exp_t;

   exp_t          sb[$];
   exp_t          wq[$];
   exp_t          mon_e;
   exp_t          wmon_e;
   int            n_acc = 0;
   bit            exp_done = 1'b0;
   bit            stalled = 1'b0;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_addr;
   int            ready_mode = 0;
   int            hc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Main monitor: pops the scoreboard on each handshake that abort does not cancel.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_done = 1'b0;
         stalled  = 1'b0;
      end else begin
         chk("done_pulse", m_done, exp_done);
         exp_done = 1'b0;
         chk("re_while_valid", m_re & m_valid, 0);
         if (m_valid && stalled) begin
            chk("stall_data", m_odata, prev_data);
            chk("stall_addr", m_oaddr, prev_addr);
         end
         stalled   = m_valid && !m_ready;
         prev_data = m_odata;
         prev_addr = m_oaddr;
         if (m_valid && m_ready && !m_abort) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_word");
            end else begin
               mon_e = sb.pop_front();
               chk("word_addr", m_oaddr, mon_e.a);
               chk("word_data", m_odata, mon_e.d);
               n_acc++;
               if (mon_e.last) exp_done = 1'b1;
            end
         end
      end
   end

   // Wrap-instance monitor.
   always @(negedge clk) begin
      if (rst_n && w_valid && w_ready) begin
         if (wq.size() == 0) begin
            fail_now("wrap_unexpected_word");
         end else begin
            wmon_e = wq.pop_front();
            chk("wrap_addr", w_oaddr, wmon_e.a);
            chk("wrap_data", w_odata, wmon_e.d);
         end
      end
      if (rst_n) chk("zero_no_traffic", z_re | z_valid, 0);
   end

   // Consumer: always ready, ready on the third cycle of each offered word, or random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: m_ready = 1'b1;
         1: begin
            hc      = m_valid ? hc + 1 : 0;
            m_ready = (hc >= 3);
         end
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill_mem(input bit preset);
      for (int i = 0; i < 16; i++) mem[i] = preset ? 32'hA0 + 32'(i) : $urandom;
   endtask

   // Expected dump: NUM words, ascending from base 0 in steps of 4, data from memory image.
   task automatic push_dump();
      exp_t e;
      for (int i = 0; i < NW; i++) begin
         e.a    = 32'(4 * i);
         e.d    = mem[i];
         e.last = (i == NW - 1);
         sb.push_back(e);
      end
   endtask

   task automatic start_dump();
      m_start = 1'b1;
      push_dump();
      tick();
      m_start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c = 0;
      while (m_busy && c < budget) begin
         tick();
         c++;
      end
      if (c >= budget) fail_now({name, "_timeout"});
      tick();
      chk({name, "_leftover"}, sb.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int c;
      int a0;
      int abort_at;
      exp_t e;
      fill_mem(1'b1);
      tick(2);
      // Reset state
      chk("rst_mem_re", m_re, 0);
      chk("rst_mem_addr", m_maddr, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_odata", m_odata, 0);
      chk("rst_oaddr", m_oaddr, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_zero_busy", z_busy | z_done, 0);
      chk("rst_wrap_busy", w_busy | w_done, 0);
      rst_n = 1'b1;
      tick(2);

      // Preloaded dump, ready always high, with first-word latency
      ready_mode = 0;
      m_start = 1'b1;
      push_dump();
      tick();
      m_start = 1'b0;
      chk("lat_busy", m_busy, 1);
      chk("lat_read_re", m_re, 1);
      chk("lat_read_addr", m_maddr, 0);
      chk("lat_c1_valid", m_valid, 0);
      tick();
      chk("lat_c2_re", m_re, 0);
      chk("lat_c2_valid", m_valid, 0);
      tick();
      chk("lat_c3_valid", m_valid, 1);
      wait_idle("preload", 100);

      // Backpressure 0,0,1 per word
      ready_mode = 1;
      start_dump();
      wait_idle("backpressure", 200);
      ready_mode = 0;

      // Start while busy is ignored
      fill_mem(1'b0);
      start_dump();
      tick(2);
      m_start = 1'b1;
      tick();
      m_start = 1'b0;
      wait_idle("start_busy", 100);

      // Start on the DONE->IDLE cycle is ignored
      start_dump();
      c = 0;
      while (!m_done && c < 100) begin
         tick();
         c++;
      end
      if (c >= 100) fail_now("wait_done_timeout");
      m_start = 1'b1;
      tick();
      m_start = 1'b0;
      chk("start_at_done_idle", m_busy, 0);
      tick(3);
      chk("start_at_done_still_idle", m_busy, 0);

      // Abort during the second HOLD with ready high, then replay
      fill_mem(1'b0);
      a0 = n_acc;
      start_dump();
      c = 0;
      while (!(n_acc == a0 + 1 && m_valid) && c < 100) begin
         tick();
         c++;
      end
      if (c >= 100) fail_now("wait_hold2_timeout");
      m_abort = 1'b1;
      tick();
      m_abort = 1'b0;
      chk("abort_busy", m_busy, 0);
      chk("abort_valid", m_valid, 0);
      chk("abort_done", m_done, 0);
      chk("abort_re", m_re, 0);
      chk("abort_remaining", sb.size(), NW - 1);
      sb.delete();
      tick(3);
      start_dump();
      wait_idle("replay", 100);

      // Abort together with start in IDLE has no effect
      m_start = 1'b1;
      m_abort = 1'b1;
      push_dump();
      tick();
      m_start = 1'b0;
      m_abort = 1'b0;
      chk("idle_abort_start_busy", m_busy, 1);
      wait_idle("idle_abort", 100);

      // Async reset mid-WAIT, then a clean dump
      fill_mem(1'b0);
      start_dump();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_mem_re", m_re, 0);
      chk("arst_mem_addr", m_maddr, 0);
      chk("arst_valid", m_valid, 0);
      chk("arst_odata", m_odata, 0);
      chk("arst_oaddr", m_oaddr, 0);
      chk("arst_busy", m_busy, 0);
      chk("arst_done", m_done, 0);
      sb.delete();
      tick(2);
      rst_n = 1'b1;
      tick();
      start_dump();
      wait_idle("post_reset", 100);

      // Randomized dumps with random backpressure, aborts and stray starts
      for (int it = 0; it < 30; it++) begin
         fill_mem(1'b0);
         ready_mode = $urandom_range(0, 2);
         abort_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
         start_dump();
         if (abort_at != 0) begin
            tick(abort_at - 1);
            m_abort = 1'b1;
            tick();
            m_abort = 1'b0;
            sb.delete();
            chk("rand_abort_busy", m_busy, 0);
            tick();
         end else begin
            if ($urandom_range(0, 2) == 0) begin
               tick(1);
               m_start = 1'b1;
               tick();
               m_start = 1'b0;
            end
            wait_idle("rand", 300);
         end
      end
      ready_mode = 0;
      tick(2);

      // Empty dump: done one cycle after start, no memory or output traffic
      z_start = 1'b1;
      tick();
      z_start = 1'b0;
      chk("zero_done", z_done, 1);
      chk("zero_busy", z_busy, 1);
      tick();
      chk("zero_done_off", z_done, 0);
      chk("zero_busy_off", z_busy, 0);
      chk("zero_addr", z_maddr | z_oaddr, 0);
      chk("zero_data", z_odata, 0);

      // Wrapping dump
      for (int i = 0; i < W_NW; i++) begin
         e.a    = W_BASE + 32'(4 * i);
         e.d    = ~e.a;
         e.last = (i == W_NW - 1);
         wq.push_back(e);
      end
      w_start = 1'b1;
      tick();
      w_start = 1'b0;
      c = 0;
      while (w_busy && c < 100) begin
         tick();
         c++;
      end
      if (c >= 100) fail_now("wrap_timeout");
      chk("wrap_leftover", wq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
